// File: rtl/konark_hwpe_ctrl_pkg.sv
// Shared definitions for the Konark HWPE control slave: register map, STATUS
// layout, controller FSM states and the byte-strobe merge helper.
package konark_hwpe_ctrl_pkg;

  // Word offsets (addr[7:2]) of the control registers.
  localparam logic [5:0] REG_TRIGGER    = 6'h00;
  localparam logic [5:0] REG_ACQUIRE    = 6'h01;
  localparam logic [5:0] REG_STATUS     = 6'h02;
  localparam logic [5:0] REG_JOB_ID     = 6'h03;
  localparam logic [5:0] REG_SOFT_CLEAR = 6'h04;
  localparam logic [5:0] REG_JOB_BASE   = 6'h10;

  localparam int STATUS_ERR_BIT   = 31;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_BUSY_BIT  = 0;

  localparam logic [31:0] ACQUIRE_FAIL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/konark_hwpe_ctx_regfile.sv
// Job-register contexts: NrContext x NrJobRegs 32-bit words, one byte-masked
// write port, one word read port for the cores and a full-context read port.
module konark_hwpe_ctx_regfile
  import konark_hwpe_ctrl_pkg::*;
#(
  parameter int NrContext = 2,
  parameter int NrJobRegs = 16,
  localparam int PtrW = $clog2(NrContext),
  localparam int IdxW = $clog2(NrJobRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [PtrW-1:0]         wctx_i,
  input  logic [IdxW-1:0]         widx_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              wstrb_i,
  input  logic [PtrW-1:0]         rctx_a_i,
  input  logic [IdxW-1:0]         ridx_a_i,
  output logic [31:0]             rdata_a_o,
  input  logic [PtrW-1:0]         rctx_b_i,
  output logic [NrJobRegs*32-1:0] rdata_b_o
);

  logic [31:0] mem_q [NrContext][NrJobRegs];

  // NOTE: the array is cleared on reset because job_regs_o and core reads must
  // return 0 straight out of reset; this is deliberate, not a habit to copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NrContext; c++) begin
        for (int r = 0; r < NrJobRegs; r++) begin
          mem_q[c][r] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wctx_i][widx_i] <= apply_strb(mem_q[wctx_i][widx_i], wdata_i, wstrb_i);
    end
  end

  assign rdata_a_o = mem_q[rctx_a_i][ridx_a_i];

  for (genvar g = 0; g < NrJobRegs; g++) begin : g_job_regs
    assign rdata_b_o[g*32 +: 32] = mem_q[rctx_b_i][g];
  end

endmodule

// File: rtl/konark_hwpe_ctrl_slave.sv
// HWPE control-port responder: decodes core register accesses, queues job
// contexts in FIFO order and sequences them onto the accelerator datapath.
module konark_hwpe_ctrl_slave
  import konark_hwpe_ctrl_pkg::*;
#(
  parameter int NrCores   = 9,
  parameter int NrContext = 2,
  parameter int NrJobRegs = 16,
  parameter int IdWidth   = 2,
  parameter int AddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic                    req_write_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [3:0]              req_strb_i,
  input  logic [IdWidth-1:0]      req_id_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic [IdWidth-1:0]      rsp_id_o,
  output logic                    job_start_o,
  output logic [NrJobRegs*32-1:0] job_regs_o,
  input  logic                    job_done_i,
  output logic                    clear_o,
  output logic                    busy_o,
  output logic [NrCores-1:0]      evt_o
);

  localparam int PtrW = $clog2(NrContext);
  localparam int CntW = PtrW + 1;
  localparam int IdxW = $clog2(NrJobRegs);

  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [CntW-1:0]    count_q;
  logic [7:0]         job_id_q;
  logic               err_q;
  ctrl_state_e        state_q, state_d;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic [IdWidth-1:0] rsp_id_q;
  logic               clear_q;
  logic [NrCores-1:0] evt_q;

  logic [5:0]      word, job_off;
  logic [IdxW-1:0] job_idx;
  logic            is_job, full, running;
  logic            req_fire, wr_fire;
  logic            do_trigger, trigger_err, do_clear, job_we, done_ok;
  logic [31:0]     ctx_rdata, rdata_d;
  logic            unused_addr;

  assign req_ready_o = rst_ni;
  assign req_fire    = req_valid_i & req_ready_o;
  assign wr_fire     = req_fire & req_write_i;

  assign word        = req_addr_i[7:2];
  assign job_off     = word - REG_JOB_BASE;
  assign job_idx     = job_off[IdxW-1:0];
  assign is_job      = (word >= REG_JOB_BASE) && (int'(job_off) < NrJobRegs);
  assign unused_addr = ^{req_addr_i[AddrWidth-1:8], req_addr_i[1:0], job_off[5:IdxW]};

  assign full    = (count_q == CntW'(NrContext));
  assign running = (state_q != ST_IDLE);

  // A full queue means context wptr is queued or running, so it is read-only.
  assign do_trigger  = wr_fire & (word == REG_TRIGGER) & !full;
  assign trigger_err = wr_fire & (word == REG_TRIGGER) & full;
  assign do_clear    = wr_fire & (word == REG_SOFT_CLEAR);
  assign job_we      = wr_fire & is_job & !full;
  assign done_ok     = job_done_i & (state_q == ST_RUN) & !do_clear;

  konark_hwpe_ctx_regfile #(
    .NrContext (NrContext),
    .NrJobRegs (NrJobRegs)
  ) i_ctx_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (job_we),
    .wctx_i    (wptr_q),
    .widx_i    (job_idx),
    .wdata_i   (req_wdata_i),
    .wstrb_i   (req_strb_i),
    .rctx_a_i  (wptr_q),
    .ridx_a_i  (job_idx),
    .rdata_a_o (ctx_rdata),
    .rctx_b_i  (rptr_q),
    .rdata_b_o (job_regs_o)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rdata_d = '0;
    if (!req_write_i) begin
      if (is_job) begin
        rdata_d = ctx_rdata;
      end else begin
        case (word)
          REG_ACQUIRE: rdata_d = full ? ACQUIRE_FAIL : 32'(wptr_q);
          REG_STATUS: begin
            rdata_d[STATUS_ERR_BIT]             = err_q;
            rdata_d[STATUS_COUNT_LSB +: 8]      = 8'(count_q);
            rdata_d[STATUS_BUSY_BIT]            = running;
          end
          REG_JOB_ID:  rdata_d = 32'(job_id_q);
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments so every update below sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_id_q    <= '0;
      clear_q     <= 1'b0;
      evt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      job_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= req_fire;
      if (req_fire) begin
        rsp_rdata_q <= rdata_d;
        rsp_id_q    <= req_id_i;
      end
      clear_q <= do_clear;
      evt_q   <= {NrCores{done_ok}};
      if (do_clear) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (do_trigger) begin
          wptr_q   <= wptr_q + 1'b1;
          job_id_q <= job_id_q + 8'd1;
        end
        if (trigger_err) err_q <= 1'b1;
        if (done_ok) rptr_q <= rptr_q + 1'b1;
        case ({do_trigger, done_ok})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (count_q != '0) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (job_done_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (do_clear) state_d = ST_IDLE;
  end

  always_comb begin
    job_start_o = (state_q == ST_START);
    busy_o      = running;
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_id_o    = rsp_id_q;
  assign clear_o     = clear_q;
  assign evt_o       = evt_q;

endmodule

// File: tb/tb_konark_hwpe_ctrl_slave.sv
// Directed bench for konark_hwpe_ctrl_slave: register map, job queue,
// job sequencing, events, soft clear and reset, with hand-computed values.
module tb_konark_hwpe_ctrl_slave;

  localparam int NrCores   = 9;
  localparam int NrContext = 2;
  localparam int NrJobRegs = 16;
  localparam int IdWidth   = 2;
  localparam int AddrWidth = 32;

  localparam logic [NrCores-1:0] EVT_ALL = 9'h1FF;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AddrWidth-1:0]    req_addr_i;
  logic                    req_write_i;
  logic [31:0]             req_wdata_i;
  logic [3:0]              req_strb_i;
  logic [IdWidth-1:0]      req_id_i;
  logic                    rsp_valid_o;
  logic [31:0]             rsp_rdata_o;
  logic [IdWidth-1:0]      rsp_id_o;
  logic                    job_start_o;
  logic [NrJobRegs*32-1:0] job_regs_o;
  logic                    job_done_i;
  logic                    clear_o;
  logic                    busy_o;
  logic [NrCores-1:0]      evt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  konark_hwpe_ctrl_slave #(
    .NrCores   (NrCores),
    .NrContext (NrContext),
    .NrJobRegs (NrJobRegs),
    .IdWidth   (IdWidth),
    .AddrWidth (AddrWidth)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_strb_i  (req_strb_i),
    .req_id_i    (req_id_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_id_o    (rsp_id_o),
    .job_start_o (job_start_o),
    .job_regs_o  (job_regs_o),
    .job_done_i  (job_done_i),
    .clear_o     (clear_o),
    .busy_o      (busy_o),
    .evt_o       (evt_o)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; issues one request and returns on the next
  // falling edge, where the registered response must be present.
  task automatic access(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [IdWidth-1:0] id,
                        output logic [31:0] rdata);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_id_i    = id;
    @(negedge clk_i);
    check("rsp_valid", rsp_valid_o, 1'b1);
    check("rsp_id", rsp_id_o, id);
    rdata       = rsp_rdata_o;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    access(1'b0, addr, 32'h0, 4'h0, 2'd3, data);
    check(tag, data, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] data;
    access(1'b1, addr, wdata, strb, 2'd1, data);
    check("wr_rdata_zero", data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    req_id_i    = '0;
    job_done_i  = 1'b0;
    repeat (3) @(negedge clk_i);

    check("rst_ready", req_ready_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_start", job_start_o, 1'b0);
    check("rst_clear", clear_o, 1'b0);
    check("rst_evt", evt_o, '0);
    check("rst_job_regs", job_regs_o, '0);

    rst_ni = 1'b1;
    check("ready_after_rst", req_ready_o, 1'b1);
    @(negedge clk_i);
    check("rsp_valid_idle", rsp_valid_o, 1'b0);

    // First access: ACQUIRE with id 2 echoed, then response drops after one cycle.
    access(1'b0, 32'h04, 32'h0, 4'h0, 2'd2, data);
    check("acquire_reset", data, 32'h0);
    @(negedge clk_i);
    check("rsp_valid_one_cycle", rsp_valid_o, 1'b0);

    // Byte-masked job register write.
    wr(32'h40, 32'hDEAD_BEEF, 4'b0011);
    rd("jobreg_masked", 32'h40, 32'h0000_BEEF);

    // Trigger: start pulse two cycles after the trigger request cycle.
    wr(32'h00, 32'h1, 4'hF);
    check("start_not_early", job_start_o, 1'b0);
    @(negedge clk_i);
    check("start_pulse", job_start_o, 1'b1);
    check("busy_start", busy_o, 1'b1);
    check("job_regs_ctx0", job_regs_o[31:0], 32'h0000_BEEF);
    @(negedge clk_i);
    check("start_one_cycle", job_start_o, 1'b0);
    check("busy_run", busy_o, 1'b1);
    rd("status_one_job", 32'h08, 32'h0000_0101);
    rd("job_id_1", 32'h0C, 32'h1);
    rd("acquire_wptr1", 32'h04, 32'h1);

    // Fill the queue while the datapath is stalled.
    wr(32'h40, 32'h1111_2222, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd("acquire_full", 32'h04, 32'hFFFF_FFFF);
    wr(32'h40, 32'h3333_3333, 4'hF);
    wr(32'h00, 32'h1, 4'hF);
    rd("status_full_err", 32'h08, 32'h8000_0201);
    rd("write_dropped_full", 32'h40, 32'h0000_BEEF);
    rd("job_id_no_inc_on_err", 32'h0C, 32'h2);

    // Completion of job 0, then job 1 launches two cycles after done.
    job_done_i = 1'b1;
    @(negedge clk_i);
    job_done_i = 1'b0;
    check("evt_all", evt_o, EVT_ALL);
    check("busy_after_done", busy_o, 1'b0);
    check("no_start_in_idle", job_start_o, 1'b0);
    @(negedge clk_i);
    check("evt_one_cycle", evt_o, '0);
    check("start_second", job_start_o, 1'b1);
    check("job_regs_ctx1", job_regs_o[31:0], 32'h1111_2222);
    @(negedge clk_i);
    rd("status_after_done", 32'h08, 32'h8000_0101);

    // Trigger and completion in the same cycle.
    job_done_i = 1'b1;
    access(1'b1, 32'h00, 32'h1, 4'hF, 2'd0, data);
    job_done_i = 1'b0;
    check("evt_same_cycle", evt_o, EVT_ALL);
    @(negedge clk_i);
    check("start_third", job_start_o, 1'b1);
    check("job_regs_ctx0_again", job_regs_o[31:0], 32'h0000_BEEF);
    @(negedge clk_i);
    rd("status_count_kept", 32'h08, 32'h8000_0101);
    rd("job_id_3", 32'h0C, 32'h3);

    // Soft clear while running; a late done is ignored.
    wr(32'h10, 32'h1, 4'hF);
    check("clear_pulse", clear_o, 1'b1);
    check("busy_cleared", busy_o, 1'b0);
    job_done_i = 1'b1;
    @(negedge clk_i);
    job_done_i = 1'b0;
    check("clear_one_cycle", clear_o, 1'b0);
    check("late_done_no_evt", evt_o, '0);
    @(negedge clk_i);
    check("late_done_no_evt2", evt_o, '0);
    check("no_start_after_clear", job_start_o, 1'b0);
    rd("status_after_clear", 32'h08, 32'h0);
    rd("acquire_after_clear", 32'h04, 32'h0);

    // Context contents survive soft clear; byte mask on upper half.
    rd("ctx_kept", 32'h40, 32'h0000_BEEF);
    wr(32'h40, 32'hAABB_CCDD, 4'b1100);
    rd("jobreg_upper_mask", 32'h40, 32'hAABB_BEEF);
    rd("unmapped_read", 32'h20, 32'h0);
    wr(32'h24, 32'hFFFF_FFFF, 4'hF);
    rd("jobreg_out_of_range", 32'h80, 32'h0);
    rd("status_unmapped_write", 32'h08, 32'h0);

    // Reset in the middle of a job zeroes everything without clear_o.
    wr(32'h00, 32'h1, 4'hF);
    @(negedge clk_i);
    @(negedge clk_i);
    check("busy_before_reset", busy_o, 1'b1);
    check("job_regs_before_reset", job_regs_o[31:0], 32'hAABB_BEEF);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("busy_reset_midjob", busy_o, 1'b0);
    check("job_regs_reset_midjob", job_regs_o, '0);
    check("no_clear_on_reset", clear_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd("ctx_zeroed_by_reset", 32'h40, 32'h0);
    rd("job_id_reset", 32'h0C, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
